slice_packer: RTL
=================

// Module: slice_packer
// PURPOSE
//   Write-side counterpart of the part-select slice extractors: packs a stream of
//   SLICE_W-bit slices into one DATA_W-bit word using indexed part-select insertion.
//   Ascending mode (+:) fills from bit 0 upward; descending mode (-:) fills from the MSB down.
//   Sits between a narrow slice producer and a word-wide consumer, valid/ready on both sides.
// PARAMETERS
//   DATA_W   32  output word width; must be an integer multiple of SLICE_W
//   SLICE_W  4   input slice width
//   NUM_SL   DATA_W/SLICE_W (localparam)  slices per full word
//   CNT_W    $clog2(NUM_SL+1) (localparam)  width of m_count
// PORTS
//   clk      in   1        single clock; all state changes on rising edge
//   rst      in   1        reset, synchronous and active-high
//   s_valid  in   1        slice valid
//   s_ready  out  1        packer can accept a slice
//   s_slice  in   SLICE_W  slice data
//   s_dir    in   1        0: ascending (+:), 1: descending (-:); sampled on first slice of a word only
//   s_last   in   1        slice closes the word early; unfilled bits are zero
//   m_valid  out  1        packed word valid
//   m_ready  in   1        consumer accepts word
//   m_data   out  DATA_W   packed word
//   m_count  out  CNT_W    number of slices in m_data (1..NUM_SL)
// BEHAVIOUR
//   - Reset (rst=1 at an edge): m_valid=0, m_data=0, m_count=0, accumulator=0, idx=0,
//     dir latch=0, state=EMPTY. Reset mid-word discards the partial word and any pending
//     word; s_ready=1 from the first cycle after reset.
//   - Accept: a slice is accepted on an edge with s_valid && s_ready.
//   - Insert position for slice index k (0-based within the word):
//     ascending  -> acc[k*SLICE_W +: SLICE_W]
//     descending -> acc[DATA_W-1-k*SLICE_W -: SLICE_W]
//   - Direction is latched when k=0; s_dir is ignored for k>0.
//   - A word completes on acceptance of slice k=NUM_SL-1, or of any slice with s_last=1.
//   - Output register is free when !m_valid || m_ready.
//   - States:
//     EMPTY: idx=0, s_ready=1. Accept with no completion -> FILL. Accept with completion
//            (s_last) follows the completion rule below.
//     FILL:  0<idx<NUM_SL, s_ready=1. Accept inserts the slice and increments idx.
//     PEND:  complete word held in the accumulator, s_ready=0. When the output register is
//            free: load m_data/m_count, clear the accumulator, go to EMPTY.
//   - Completion rule: if the output register is free on the completing edge, load
//     m_data = acc | inserted slice and m_count = k+1, set m_valid, clear the accumulator,
//     go to EMPTY. Otherwise store the slice into the accumulator and go to PEND.
//   - Latency: completing slice accepted at edge n -> m_valid=1 after edge n (visible in
//     cycle n+1) when the output register is free.
//   - m_valid clears on m_valid && m_ready unless a new load occurs on the same edge.
//     A same-edge drain and load gives back-to-back words with no bubble.
//   - m_data and m_count are stable while m_valid && !m_ready.
//   - Sustained throughput is 1 slice/cycle; s_ready drops only in PEND.
//   - Bits not written in a short (s_last) word are 0.
// TESTING
//   - Ascending, s_dir=0, slices 1,2,...,8, m_ready=1 -> m_data=0x87654321, m_count=8,
//     m_valid one cycle after the 8th accept.
//   - Descending, s_dir=1, slices 1..8 -> m_data=0x12345678, m_count=8.
//   - Short word: ascending A,B,C with s_last on C -> m_data=0x00000CBA, m_count=3.
//     Descending A,B with s_last -> m_data=0xAB000000, m_count=2.
//   - Backpressure, m_ready=0: word 1 (0x87654321) held stable; word 2 fills and reaches
//     PEND (s_ready=0). Raise m_ready -> word 1 drains, word 2 loads on the same edge,
//     then drains; s_ready returns to 1.
//   - Mid-word s_dir toggle: s_dir=0 on slice 0, then s_dir=1 on the rest -> result
//     identical to the all-ascending case.
//   - rst pulse after 5 accepted slices -> m_valid=0 and state EMPTY; next 8 slices
//     1..8 ascending -> m_data=0x87654321 with no residue from the aborted word.

Source files
------------

// File: rtl/slice_packer.sv
// slice_packer: packs SLICE_W-bit slices into a DATA_W-bit word, ascending (+:) or descending (-:)
// clk, rst            : clock, synchronous active-high reset
// s_valid/s_ready     : slice handshake; s_slice data, s_dir direction (first slice), s_last early close
// m_valid/m_ready     : word handshake; m_data packed word, m_count slices in the word
module slice_packer #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 4,
    localparam int NUM_SL = DATA_W / SLICE_W,
    localparam int CNT_W  = $clog2(NUM_SL + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SLICE_W-1:0] s_slice,
    input  logic               s_dir,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic [CNT_W-1:0]   m_count
);
    typedef enum logic [1:0] {EMPTY, FILL, PEND} state_t;
    state_t state, nxt;
    logic [DATA_W-1:0] acc, ins, merged, load_data;
    logic [CNT_W-1:0]  idx, load_cnt;
    logic              dir, cur_dir, take, done, out_free, load;
    int                pos;
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= nxt;
    end
    always_comb begin
        nxt = state;
        if (state == PEND) nxt = out_free ? EMPTY : PEND;
        else if (take)     nxt = done ? (out_free ? EMPTY : PEND) : FILL;
    end
    always_comb begin
        s_ready   = state != PEND;
        take      = s_valid && s_ready;
        out_free  = !m_valid || m_ready;
        cur_dir   = (idx == '0) ? s_dir : dir;
        pos       = cur_dir ? DATA_W - (int'(idx) + 1) * SLICE_W : int'(idx) * SLICE_W;
        ins       = DATA_W'(s_slice) << pos;
        merged    = acc | ins;
        done      = take && (s_last || idx == CNT_W'(NUM_SL - 1));
        // PEND keeps the finished word and its slice count in acc/idx
        load      = out_free && (done || state == PEND);
        load_data = (state == PEND) ? acc : merged;
        load_cnt  = (state == PEND) ? idx : idx + CNT_W'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= '0;
            acc     <= '0;
            idx     <= '0;
            dir     <= 1'b0;
        end else begin
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= load_data;
                m_count <= load_cnt;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (load) begin
                acc <= '0;
                idx <= '0;
            end else if (take) begin
                acc <= merged;
                idx <= idx + CNT_W'(1);
            end
            if (take && idx == '0) dir <= s_dir;
        end
    end
endmodule
